data_mem_access_unit: RTL and testbench



---
 rtl/mips_mem_pkg.sv | 42 ++++
 rtl/mips_ls_align.sv | 69 ++++++
 rtl/data_mem_access_unit.sv | 108 ++++++++++
 tb/tb_data_mem_access_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS data-memory access unit:
// load/store op codes, FSM states and access-size helpers.
package mips_mem_pkg;

    typedef enum logic [2:0] {
        LS_LB  = 3'd0,
        LS_LH  = 3'd1,
        LS_LW  = 3'd2,
        LS_LBU = 3'd3,
        LS_LHU = 3'd4,
        LS_SB  = 3'd5,
        LS_SH  = 3'd6,
        LS_SW  = 3'd7
    } ls_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_CAP,
        ST_WR_REQ,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    function automatic logic is_store(ls_op_e op);
        return op inside {LS_SB, LS_SH, LS_SW};
    endfunction

    function automatic size_e access_size(ls_op_e op);
        case (op)
            LS_LW, LS_SW:         return SZ_WORD;
            LS_LH, LS_LHU, LS_SH: return SZ_HALF;
            default:              return SZ_BYTE;
        endcase
    endfunction

endpackage

// File: rtl/mips_ls_align.sv
// Big-endian lane handling: load extraction/extension, store merge
// into a full RAM word, and alignment check.
module mips_ls_align
    import mips_mem_pkg::*;
(
    input  ls_op_e      op,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged,
    output logic        misaligned
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Offset 0 is the most significant lane
    always_comb begin
        case (offset)
            2'd0:    lane_b = word[31:24];
            2'd1:    lane_b = word[23:16];
            2'd2:    lane_b = word[15:8];
            default: lane_b = word[7:0];
        endcase
        lane_h = offset[1] ? word[15:0] : word[31:16];
    end

    always_comb begin
        rdata = word;
        case (op)
            LS_LB:   rdata = {{24{lane_b[7]}}, lane_b};
            LS_LBU:  rdata = {24'd0, lane_b};
            LS_LH:   rdata = {{16{lane_h[15]}}, lane_h};
            LS_LHU:  rdata = {16'd0, lane_h};
            default: rdata = word;
        endcase
    end

    always_comb begin
        merged = word;
        case (op)
            LS_SB: begin
                case (offset)
                    2'd0:    merged[31:24] = wdata[7:0];
                    2'd1:    merged[23:16] = wdata[7:0];
                    2'd2:    merged[15:8]  = wdata[7:0];
                    default: merged[7:0]   = wdata[7:0];
                endcase
            end
            LS_SH: begin
                if (offset[1]) merged[15:0]  = wdata[15:0];
                else           merged[31:16] = wdata[15:0];
            end
            LS_SW:   merged = wdata;
            default: merged = word;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (access_size(op))
            SZ_WORD: misaligned = (offset != 2'd0);
            SZ_HALF: misaligned = offset[0];
            default: misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/data_mem_access_unit.sv
// Single-outstanding load/store initiator for a word-wide synchronous
// RAM; sub-word stores are done by read-modify-write.
module data_mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ls_req,
    input  logic [2:0]               ls_op,
    input  logic [31:0]              ls_addr,
    input  logic [31:0]              ls_wdata,
    output logic                     ls_ready,
    output logic                     ls_done,
    output logic [31:0]              ls_rdata,
    output logic                     ls_err,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    state_e      state, state_n;
    ls_op_e      op_q, in_op, a_op;
    logic [1:0]  off_q, a_off;
    logic [31:0] wdata_q;
    logic [31:0] ext_data, merged;
    logic        misaligned, accept;
    logic        unused_hi;

    // Upper address bits wrap silently
    assign unused_hi = ^ls_addr[31:ADDRESS_WIDTH+2];

    assign in_op    = ls_op_e'(ls_op);
    assign ls_ready = (state == ST_IDLE);
    assign accept   = ls_ready && ls_req;
    assign a_op     = ls_ready ? in_op : op_q;
    assign a_off    = ls_ready ? ls_addr[1:0] : off_q;

    mips_ls_align u_align (
        .op         (a_op),
        .offset     (a_off),
        .word       (mem_rdata),
        .wdata      (wdata_q),
        .rdata      (ext_data),
        .merged     (merged),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (ls_req) begin
                    if (misaligned)         state_n = ST_DONE;
                    else if (in_op == LS_SW) state_n = ST_WR_REQ;
                    else                    state_n = ST_RD_REQ;
                end
            end
            ST_RD_REQ: state_n = ST_RD_CAP;
            ST_RD_CAP: state_n = is_store(op_q) ? ST_WR_REQ : ST_DONE;
            ST_WR_REQ: state_n = ST_DONE;
            ST_DONE:   state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= LS_LB;
            off_q     <= 2'd0;
            wdata_q   <= 32'd0;
            ls_done   <= 1'b0;
            ls_err    <= 1'b0;
            ls_rdata  <= 32'd0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en  <= (state_n == ST_RD_REQ) || (state_n == ST_WR_REQ);
            mem_we  <= (state_n == ST_WR_REQ);
            ls_done <= (state_n == ST_DONE);
            ls_err  <= accept && misaligned;
            if (accept) begin
                op_q     <= in_op;
                off_q    <= ls_addr[1:0];
                wdata_q  <= ls_wdata;
                mem_addr <= ls_addr[ADDRESS_WIDTH+1:2];
                if (in_op == LS_SW && !misaligned) mem_wdata <= ls_wdata;
            end
            if (state == ST_RD_CAP) begin
                if (is_store(op_q)) mem_wdata <= merged;
                else                ls_rdata  <= ext_data;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed self-checking bench for data_mem_access_unit with a
// write-first synchronous RAM model.
module tb_data_mem_access_unit;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ls_req;
    logic [2:0]  ls_op;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_ready;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        ram_init;

    logic [31:0] ram [256];

    int checks = 0;
    int errors = 0;

    int          r_done;
    int          r_we;
    int          r_en;
    logic [7:0]  r_addr1;
    logic [31:0] r_rdata;
    logic        r_err;

    always #5 clk = ~clk;

    data_mem_access_unit #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .ls_req    (ls_req),
        .ls_op     (ls_op),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_ready  (ls_ready),
        .ls_done   (ls_done),
        .ls_rdata  (ls_rdata),
        .ls_err    (ls_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'd0;
            ram[3]    <= 32'hFFFFFFFE;
            ram[127]  <= 32'hAAAAAAAA;
            mem_rdata <= 32'd0;
        end else if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                mem_rdata     <= mem_wdata;
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    // Issue one request and observe 8 cycles after acceptance
    task automatic run_op(input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata);
        r_done = 0; r_we = 0; r_en = 0;
        r_addr1 = 8'hxx; r_rdata = 32'hxxxxxxxx; r_err = 1'bx;
        @(negedge clk);
        ls_req = 1'b1; ls_op = op; ls_addr = addr; ls_wdata = wdata;
        @(posedge clk);
        #1 ls_req = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_en) r_en++;
            if (mem_we) r_we++;
            if (c == 1) r_addr1 = mem_addr;
            if (ls_done && r_done == 0) begin
                r_done  = c;
                r_rdata = ls_rdata;
                r_err   = ls_err;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({ls_ready, ls_done, ls_err, mem_en, mem_we} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags got %b want 10000",
                     {ls_ready, ls_done, ls_err, mem_en, mem_we});
        end
        checks++;
        if ({ls_rdata, mem_addr, mem_wdata} !== 72'd0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h want 0",
                     ls_rdata, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_byte_loads;
        run_op(LS_LB, 32'h0000000C, 32'd0);
        checks++;
        if (r_rdata !== 32'hFFFFFFFF || r_done != 3) begin
            errors++;
            $display("FAIL lb got %h cyc %0d want FFFFFFFF cyc 3", r_rdata, r_done);
        end
        run_op(LS_LBU, 32'h0000000F, 32'd0);
        checks++;
        if (r_rdata !== 32'h000000FE || r_done != 3) begin
            errors++;
            $display("FAIL lbu got %h cyc %0d want 000000FE cyc 3", r_rdata, r_done);
        end
    endtask

    task automatic test_half_loads;
        run_op(LS_LH, 32'h000001FC, 32'd0);
        checks++;
        if (r_rdata !== 32'hFFFFAAAA || r_addr1 !== 8'd127) begin
            errors++;
            $display("FAIL lh got %h addr %0d want FFFFAAAA addr 127", r_rdata, r_addr1);
        end
        run_op(LS_LHU, 32'h000001FE, 32'd0);
        checks++;
        if (r_rdata !== 32'h0000AAAA || r_en != 1) begin
            errors++;
            $display("FAIL lhu got %h en %0d want 0000AAAA en 1", r_rdata, r_en);
        end
    endtask

    task automatic test_subword_stores;
        run_op(LS_SB, 32'h000001FD, 32'h12345655);
        checks++;
        if (ram[127] !== 32'hAA55AAAA || r_we != 1 || r_done != 4) begin
            errors++;
            $display("FAIL sb got %h we %0d cyc %0d want AA55AAAA we 1 cyc 4",
                     ram[127], r_we, r_done);
        end
        run_op(LS_LW, 32'h000001FC, 32'd0);
        checks++;
        if (r_rdata !== 32'hAA55AAAA) begin
            errors++;
            $display("FAIL lw_after_sb got %h want AA55AAAA", r_rdata);
        end
        run_op(LS_SH, 32'h0000000E, 32'h00001234);
        checks++;
        if (ram[3] !== 32'hFFFF1234 || r_err !== 1'b0) begin
            errors++;
            $display("FAIL sh got %h err %b want FFFF1234 err 0", ram[3], r_err);
        end
    endtask

    task automatic test_word_store;
        run_op(LS_SW, 32'h00000010, 32'hDEADBEEF);
        checks++;
        if (r_we != 1 || r_done != 2 || ram[4] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw we %0d cyc %0d mem %h want we 1 cyc 2 DEADBEEF",
                     r_we, r_done, ram[4]);
        end
        run_op(LS_LW, 32'h00000010, 32'd0);
        checks++;
        if (r_rdata !== 32'hDEADBEEF || r_done != 3) begin
            errors++;
            $display("FAIL lw_after_sw got %h cyc %0d want DEADBEEF cyc 3", r_rdata, r_done);
        end
        run_op(LS_SW, 32'h00000410, 32'h0BADF00D);
        checks++;
        if (ram[4] !== 32'h0BADF00D || r_addr1 !== 8'd4 || r_err !== 1'b0) begin
            errors++;
            $display("FAIL sw_wrap got %h addr %0d err %b want 0BADF00D addr 4 err 0",
                     ram[4], r_addr1, r_err);
        end
    endtask

    task automatic test_misaligned;
        run_op(LS_LW, 32'h0000000D, 32'd0);
        checks++;
        if (r_err !== 1'b1 || r_done != 1 || r_en != 0 || r_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw_misalign err %b cyc %0d en %0d rd %h want 1 1 0 DEADBEEF",
                     r_err, r_done, r_en, r_rdata);
        end
        run_op(LS_SH, 32'h00000001, 32'hFFFFFFFF);
        checks++;
        if (r_err !== 1'b1 || r_done != 1 || r_en != 0 || ram[0] !== 32'd0) begin
            errors++;
            $display("FAIL sh_misalign err %b cyc %0d en %0d mem %h want 1 1 0 0",
                     r_err, r_done, r_en, ram[0]);
        end
        checks++;
        if (ls_err !== 1'b0 || ls_done !== 1'b0) begin
            errors++;
            $display("FAIL err_clear err %b done %b want 0 0", ls_err, ls_done);
        end
    endtask

    task automatic test_reset_mid_op;
        int we_seen = 0;
        @(negedge clk);
        ls_req = 1'b1; ls_op = LS_SB; ls_addr = 32'h00000008; ls_wdata = 32'h00000077;
        @(posedge clk);
        #1 ls_req = 1'b0;
        @(negedge clk);
        if (mem_we) we_seen++;
        @(negedge clk);
        if (mem_we) we_seen++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({ls_ready, ls_done, ls_err, mem_en, mem_we} !== 5'b10000 ||
            {ls_rdata, mem_addr, mem_wdata} !== 72'd0) begin
            errors++;
            $display("FAIL mid_reset flags %b data %h %h %h want 10000 0",
                     {ls_ready, ls_done, ls_err, mem_en, mem_we},
                     ls_rdata, mem_addr, mem_wdata);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_we) we_seen++;
        end
        checks++;
        if (we_seen != 0 || ram[2] !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_write we %0d mem %h want 0 0", we_seen, ram[2]);
        end
    endtask

    task automatic test_busy_ignored;
        int dones = 0;
        int wes = 0;
        logic [31:0] rd = 32'd0;
        @(negedge clk);
        ls_req = 1'b1; ls_op = LS_LW; ls_addr = 32'h000001FC; ls_wdata = 32'd0;
        @(posedge clk);
        #1 ls_op = LS_SW; ls_addr = 32'h00000020; ls_wdata = 32'h55555555;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 3) ls_req = 1'b0;
            if (ls_done) begin
                dones++;
                rd = ls_rdata;
            end
            if (mem_we) wes++;
        end
        checks++;
        if (dones != 1 || wes != 0 || rd !== 32'hAA55AAAA || ram[8] !== 32'd0) begin
            errors++;
            $display("FAIL busy dones %0d we %0d rd %h mem %h want 1 0 AA55AAAA 0",
                     dones, wes, rd, ram[8]);
        end
    endtask

    task automatic test_back_to_back;
        int first = 0;
        int second = 0;
        @(negedge clk);
        ls_req = 1'b1; ls_op = LS_LBU; ls_addr = 32'h000001FD; ls_wdata = 32'd0;
        @(posedge clk);
        #1 ls_op = LS_LHU; ls_addr = 32'h0000000E;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (ls_done && first == 0) begin
                first = c;
                checks++;
                if (ls_rdata !== 32'h00000055) begin
                    errors++;
                    $display("FAIL b2b_first got %h want 00000055", ls_rdata);
                end
            end else if (ls_done && second == 0) begin
                second = c;
                ls_req = 1'b0;
                checks++;
                if (ls_rdata !== 32'h00001234) begin
                    errors++;
                    $display("FAIL b2b_second got %h want 00001234", ls_rdata);
                end
            end
        end
        ls_req = 1'b0;
        checks++;
        if (first != 3 || second != 7) begin
            errors++;
            $display("FAIL b2b_timing got %0d %0d want 3 7", first, second);
        end
    endtask

    initial begin
        reset = 1'b1; ram_init = 1'b1;
        ls_req = 1'b0; ls_op = 3'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
        @(posedge clk);
        @(posedge clk);
        test_reset;
        reset = 1'b0; ram_init = 1'b0;
        test_byte_loads;
        test_half_loads;
        test_subword_stores;
        test_word_store;
        test_misaligned;
        test_reset_mid_op;
        test_busy_ignored;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
